execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Execute stage of the 5-stage RV32 pipeline, directly downstream of the ALU decoder.
//  Captures decoded operands and the 4-bit ALUControl into an ID/EX register, evaluates the ALU,
//  and holds the result in an EX/MEM register for the memory stage.
//  Elastic valid/ready on both sides: memory-stage stalls back-pressure decode. Flush squashes the younger slot.
// PARAMETERS
//  XLEN      32  datapath width; operands, result and store data
//  REG_AW    5   destination-register index width
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-low reset
//  in_valid       in   1       decode presents an instruction
//  in_ready       out  1       execute accepts this cycle
//  in_alu_ctrl    in   4       ALUControl from decoder
//  in_src_a       in   XLEN    operand A (forwarded rs1 or PC)
//  in_src_b       in   XLEN    operand B (rs2 or immediate)
//  in_store_data  in   XLEN    rs2 value for stores
//  in_rd          in   REG_AW  destination register
//  in_reg_write   in   1       writes rd
//  in_mem_write   in   1       store
//  in_result_src  in   2       writeback select, passed through
//  flush          in   1       kill ID/EX slot and current in_* beat
//  out_valid      out  1       EX/MEM slot holds an instruction
//  out_ready      in   1       memory stage accepts
//  out_result     out  XLEN    ALU result
//  out_zero       out  1       result == 0 (branch compare)
//  out_store_data out  XLEN    registered store data
//  out_rd         out  REG_AW  registered rd
//  out_reg_write  out  1       gated: 0 whenever out_valid = 0
//  out_mem_write  out  1       gated: 0 whenever out_valid = 0
//  out_result_src out  2       registered writeback select
// BEHAVIOUR
//  Reset (rst = 0 at posedge): both slots invalid; every out_* = 0. in_ready = 0 during reset,
//    1 on the first cycle after reset. Reset mid-stall discards both slots, no completion.
//  ALUControl encoding:
//    0000 add        0001 sub        0010 and      0011 or      0100 sll (shamt = b[4:0])
//    0101 slt (signed, result 0/1)   0110 xor      0111 srl     1000 sltu (unsigned, 0/1)
//    1111 sra (arithmetic)
//    Any other code -> result 0. Never X.
//  Arithmetic: add/sub wrap modulo 2^XLEN; no overflow flag.
//  Shifts use only b[4:0]; srl with shamt 0 returns a unchanged.
//  Advance rules:
//    s2_adv = !s2_valid | out_ready
//    s1_adv = s1_valid & s2_adv
//    in_ready = !s1_valid | s2_adv
//  Latency: accepted beat shows on out_* two edges after acceptance when unstalled;
//    throughput 1/cycle.
//  ALU evaluates ID/EX contents. Result and control load into EX/MEM on s1_adv.
//  If out_ready = 1 and no s1_adv, out_valid drops.
//  Stall (out_ready = 0 with s2 full): both registers hold all fields. in_ready follows s1_valid.
//  Flush (priority over all else): s1_valid <= 0, current in_* beat dropped. EX/MEM is older, unaffected.
//    Flush while s1_adv: the s1 instruction still moves to EX/MEM (already committed to advance).
//  Same-cycle accept and advance: s1 reloads with the new beat; no bubble.
//  No combinational path from in_* to out_*. in_ready depends only on state and out_ready.
// STRUCTURE
//  Package rv_alu_pkg: ALUControl localparams (ALU_ADD .. ALU_SRA); XLEN default.
//    Shared with the ALU decoder.
//  Sub-module alu_core: combinational, (a, b, ctrl) -> (result, zero).
//  Top: two slot registers and handshake logic.
// TESTING
//  1 add 7 + 5, then sub 5 - 7, back-to-back -> out_result 12 then 0xFFFFFFFE;
//    second out_valid one cycle after the first.
//  2 slt/sltu with a = 0xFFFFFFFF, b = 1 -> 1 then 0; sra 0x80000000 >> 4 -> 0xF8000000;
//    srl same -> 0x08000000.
//  3 out_ready low 3 cycles with both slots full -> in_ready = 0, outputs stable.
//    Release -> both results emerge in order.
//  4 flush with in_valid = 1 and s1 full but s2 stalled -> s1 instruction and new beat never appear;
//    EX/MEM item completes.
//  5 rst low while both slots full -> next cycle out_valid = 0, out_reg_write = 0, in_ready = 0;
//    after release, in_ready = 1.
//  6 ctrl 1010 with a = b = 0x1234 -> out_result 0, out_zero 1; sub equal operands -> out_zero 1.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg
//   Shared definitions for the RV32 ALU path: default datapath widths and the
//   4-bit ALUControl encoding produced by the ALU decoder and consumed by the
//   execute stage.
//   No ports (package).
package rv_alu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational RV32 ALU.
//   Ports:
//     a, b    in  W   operands
//     ctrl    in  4   ALUControl code
//     result  out W   ALU result (0 for unassigned codes)
//     zero    out 1   result == 0
module alu_core
  import rv_alu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] result,
  output logic         zero
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SLTU: result = {{(W-1){1'b0}}, (a < b)};
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// execute_stage
//   RV32 execute stage: ID/EX slot (s1) captures decoded operands, the ALU
//   evaluates s1, and the EX/MEM slot (s2) holds the result for the memory
//   stage. Elastic valid/ready on both sides; flush kills s1 and the incoming
//   beat but never the older s2 instruction.
//   Ports:
//     clk, rst (sync, active-low)
//     in_valid/in_ready, in_alu_ctrl, in_src_a, in_src_b, in_store_data,
//     in_rd, in_reg_write, in_mem_write, in_result_src, flush
//     out_valid/out_ready, out_result, out_zero, out_store_data, out_rd,
//     out_reg_write, out_mem_write, out_result_src
module execute_stage
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = rv_alu_pkg::XLEN,
  parameter int REG_AW = rv_alu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_ctrl,
  input  logic [XLEN-1:0]   in_src_a,
  input  logic [XLEN-1:0]   in_src_b,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic [1:0]        in_result_src,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic [1:0]        out_result_src
);

  // ID/EX slot
  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_ctrl_q, s1_ctrl_d;
  logic [XLEN-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_sd_q, s1_sd_d;
  logic [REG_AW-1:0] s1_rd_q, s1_rd_d;
  logic              s1_rw_q, s1_rw_d, s1_mw_q, s1_mw_d;
  logic [1:0]        s1_rs_q, s1_rs_d;

  // EX/MEM slot
  logic              s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]   s2_result_q, s2_result_d, s2_sd_q, s2_sd_d;
  logic              s2_zero_q, s2_zero_d;
  logic [REG_AW-1:0] s2_rd_q, s2_rd_d;
  logic              s2_rw_q, s2_rw_d, s2_mw_q, s2_mw_d;
  logic [1:0]        s2_rs_q, s2_rs_d;

  // Holds in_ready low for the cycle in which reset was last sampled.
  logic rdy_en_q, rdy_en_d;

  logic            s1_adv, s2_adv, in_fire;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  alu_core #(.W(XLEN)) u_alu (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .ctrl   (s1_ctrl_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = rdy_en_q && (!s1_valid_q || s2_adv);
  assign in_fire  = in_valid && in_ready && !flush;

  always_comb begin
    rdy_en_d    = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_ctrl_d   = s1_ctrl_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_sd_d     = s1_sd_q;
    s1_rd_d     = s1_rd_q;
    s1_rw_d     = s1_rw_q;
    s1_mw_d     = s1_mw_q;
    s1_rs_d     = s1_rs_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_sd_d     = s2_sd_q;
    s2_rd_d     = s2_rd_q;
    s2_rw_d     = s2_rw_q;
    s2_mw_d     = s2_mw_q;
    s2_rs_d     = s2_rs_q;

    // s2 advances independently of flush: s1 was already committed to move.
    if (s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_result_d = alu_result;
      s2_zero_d   = alu_zero;
      s2_sd_d     = s1_sd_q;
      s2_rd_d     = s1_rd_q;
      s2_rw_d     = s1_rw_q;
      s2_mw_d     = s1_mw_q;
      s2_rs_d     = s1_rs_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_ctrl_d  = in_alu_ctrl;
      s1_a_d     = in_src_a;
      s1_b_d     = in_src_b;
      s1_sd_d    = in_store_data;
      s1_rd_d    = in_rd;
      s1_rw_d    = in_reg_write;
      s1_mw_d    = in_mem_write;
      s1_rs_d    = in_result_src;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_en_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_ctrl_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sd_q     <= '0;
      s1_rd_q     <= '0;
      s1_rw_q     <= 1'b0;
      s1_mw_q     <= 1'b0;
      s1_rs_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_sd_q     <= '0;
      s2_rd_q     <= '0;
      s2_rw_q     <= 1'b0;
      s2_mw_q     <= 1'b0;
      s2_rs_q     <= '0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      s1_valid_q  <= s1_valid_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sd_q     <= s1_sd_d;
      s1_rd_q     <= s1_rd_d;
      s1_rw_q     <= s1_rw_d;
      s1_mw_q     <= s1_mw_d;
      s1_rs_q     <= s1_rs_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_sd_q     <= s2_sd_d;
      s2_rd_q     <= s2_rd_d;
      s2_rw_q     <= s2_rw_d;
      s2_mw_q     <= s2_mw_d;
      s2_rs_q     <= s2_rs_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_result     = s2_result_q;
  assign out_zero       = s2_zero_q;
  assign out_store_data = s2_sd_q;
  assign out_rd         = s2_rd_q;
  assign out_reg_write  = s2_valid_q && s2_rw_q;
  assign out_mem_write  = s2_valid_q && s2_mw_q;
  assign out_result_src = s2_rs_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_ctrl;
  logic [31:0] in_src_a;
  logic [31:0] in_src_b;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_write;
  logic [1:0]  in_result_src;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_write;
  logic [1:0]  out_result_src;

  int n_tests = 0;
  int n_fail  = 0;

  execute_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_ctrl    (in_alu_ctrl),
    .in_src_a       (in_src_a),
    .in_src_b       (in_src_b),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_write   (in_mem_write),
    .in_result_src  (in_result_src),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_zero       (out_zero),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_write  (out_mem_write),
    .out_result_src (out_result_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic rw, input logic mw,
                      input logic [31:0] sd);
    in_valid      = 1'b1;
    in_alu_ctrl   = ctrl;
    in_src_a      = a;
    in_src_b      = b;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_write  = mw;
    in_store_data = sd;
    in_result_src = 2'b01;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_alu_ctrl = '0; in_src_a = '0; in_src_b = '0;
    in_store_data = '0; in_rd = '0; in_reg_write = 1'b0; in_mem_write = 1'b0;
    in_result_src = '0; flush = 1'b0; out_ready = 1'b1;

    // reset state
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_reg_write", {31'd0, out_reg_write}, 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: add then sub back-to-back
    send(4'b0000, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0, 32'h0);
    tick();
    send(4'b0001, 32'd5, 32'd7, 5'd4, 1'b1, 1'b0, 32'h0);
    tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'd12);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    check("add_rw", {31'd0, out_reg_write}, 32'd1);
    check("add_rsrc", {30'd0, out_result_src}, 32'd1);
    idle();
    tick();
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_result", out_result, 32'hFFFF_FFFE);
    check("sub_rd", {27'd0, out_rd}, 32'd4);
    check("sub_zero", {31'd0, out_zero}, 32'd0);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_rw", {31'd0, out_reg_write}, 32'd0);

    // 2: compares and shifts, streamed
    send(4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1, 1'b0, 32'h0);
    tick();
    send(4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1, 1'b0, 32'h0);
    tick();
    check("slt", out_result, 32'd1);
    send(4'b1111, 32'h8000_0000, 32'd4, 5'd3, 1'b1, 1'b0, 32'h0);
    tick();
    check("sltu", out_result, 32'd0);
    send(4'b0111, 32'h8000_0000, 32'd4, 5'd4, 1'b1, 1'b0, 32'h0);
    tick();
    check("sra", out_result, 32'hF800_0000);
    send(4'b0100, 32'd1, 32'h21, 5'd5, 1'b1, 1'b0, 32'h0);
    tick();
    check("srl", out_result, 32'h0800_0000);
    send(4'b0111, 32'hA5A5_0001, 32'h20, 5'd6, 1'b1, 1'b0, 32'h0);
    tick();
    check("sll_shamt_low5", out_result, 32'd2);
    idle();
    tick();
    check("srl_shamt0", out_result, 32'hA5A5_0001);
    tick();

    // 3: stall with both slots full
    send(4'b0000, 32'd1, 32'd2, 5'd5, 1'b1, 1'b0, 32'h0);
    tick();
    send(4'b0110, 32'hF0, 32'h0F, 5'd6, 1'b1, 1'b0, 32'h0);
    out_ready = 1'b0;
    tick();
    send(4'b0011, 32'd9, 32'd6, 5'd7, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_result", out_result, 32'd3);
      check("stall_rd", {27'd0, out_rd}, 32'd5);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    check("release_b", out_result, 32'hFF);
    check("release_b_rd", {27'd0, out_rd}, 32'd6);
    tick();
    check("release_c", out_result, 32'hF);
    check("release_c_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("release_empty", {31'd0, out_valid}, 32'd0);

    // 4: flush with s2 stalled
    send(4'b0000, 32'd10, 32'd10, 5'd8, 1'b0, 1'b1, 32'h0000_DEAD);
    tick();
    send(4'b0000, 32'd1, 32'd1, 5'd9, 1'b1, 1'b0, 32'h0);
    out_ready = 1'b0;
    tick();
    send(4'b0000, 32'd2, 32'd2, 5'd10, 1'b1, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_s2_valid", {31'd0, out_valid}, 32'd1);
    check("flush_s2_result", out_result, 32'd20);
    check("flush_s2_mw", {31'd0, out_mem_write}, 32'd1);
    check("flush_s2_sd", out_store_data, 32'h0000_DEAD);
    out_ready = 1'b1;
    tick();
    check("flush_gone", {31'd0, out_valid}, 32'd0);
    check("flush_mw_gated", {31'd0, out_mem_write}, 32'd0);
    tick();
    check("flush_gone2", {31'd0, out_valid}, 32'd0);

    // flush while s1 advances: s1 still completes, new beat dropped
    send(4'b0010, 32'hFF00, 32'h0FF0, 5'd11, 1'b1, 1'b0, 32'h0);
    tick();
    send(4'b0000, 32'd3, 32'd3, 5'd12, 1'b1, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_adv_valid", {31'd0, out_valid}, 32'd1);
    check("flush_adv_result", out_result, 32'h0F00);
    tick();
    check("flush_adv_dropped", {31'd0, out_valid}, 32'd0);

    // 5: reset with both slots full
    send(4'b0000, 32'd4, 32'd4, 5'd13, 1'b1, 1'b0, 32'h0);
    tick();
    send(4'b0000, 32'd5, 32'd5, 5'd14, 1'b1, 1'b0, 32'h0);
    out_ready = 1'b0;
    tick();
    idle();
    rst = 1'b0;
    tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_rw", {31'd0, out_reg_write}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_result", out_result, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("midrst_no_completion", {31'd0, out_valid}, 32'd0);

    // 6: undefined code and equal-operand sub
    send(4'b1010, 32'h1234, 32'h1234, 5'd15, 1'b1, 1'b0, 32'h0);
    tick();
    send(4'b0001, 32'h1234, 32'h1234, 5'd16, 1'b1, 1'b0, 32'h0);
    tick();
    check("undef_result", out_result, 32'd0);
    check("undef_zero", {31'd0, out_zero}, 32'd1);
    idle();
    tick();
    check("sub_eq_result", out_result, 32'd0);
    check("sub_eq_zero", {31'd0, out_zero}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
